// File: rtl/sb_rx_oversample_fifo_if.sv
// Read-side handshake of the sideband receiver: show-ahead head word with valid/ready.
// The receiver drives the master side, the downstream decoder takes the slave side.
interface sb_rx_oversample_fifo_if #(
  parameter int PACKET_W = 64
);
  logic                rd_valid_o;
  logic [PACKET_W-1:0] rd_data_o;
  logic                rd_ready_i;

  modport master (output rd_valid_o, output rd_data_o, input rd_ready_i);
  modport slave  (input rd_valid_o, input rd_data_o, output rd_ready_i);
endinterface

// File: rtl/sb_rx_oversample_fifo.sv
// Sideband receiver: oversamples the forwarded clock/data pins, deserialises LSB first on each
// falling serial-clock edge, and buffers finished packets in a show-ahead FIFO.
module sb_rx_oversample_fifo #(
  parameter int NUM_LANES    = 1,
  parameter int PACKET_W     = 64,
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                     clk_800MHz,
  input  logic                     reset_n,
  input  logic                     enable_i,
  input  logic                     clkPin_i,
  input  logic [NUM_LANES-1:0]     dataPin_i,
  input  logic                     clear_err_i,
  sb_rx_oversample_fifo_if.master  rd_if,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic                     framing_err_o
);

  localparam int BEATS  = PACKET_W / NUM_LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [SYNC_STAGES-1:0]                clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0][NUM_LANES-1:0] data_sync_q, data_sync_d;
  logic                                  clk_prev_q, clk_prev_d;
  logic [PACKET_W-1:0]                   shift_q, shift_d;
  logic [BEAT_W-1:0]                     beat_q, beat_d;
  logic [IDLE_W-1:0]                     idle_q, idle_d;
  logic [PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                      rd_ptr_q, rd_ptr_d;
  logic                                  overflow_q, overflow_d;
  logic                                  framing_q, framing_d;

  logic [PACKET_W-1:0] mem [DEPTH];

  logic                          clk_s;
  logic [NUM_LANES-1:0]          data_s;
  logic                          edge_det;
  logic [PACKET_W+NUM_LANES-1:0] shift_cat;
  logic [PACKET_W-1:0]           shift_nxt;
  logic                          push, pop, wr_en, drop, framing_set;
  logic [PTR_W-1:0]              level;
  logic                          full, rd_valid;

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign edge_det  = clk_prev_q & ~clk_s;
  // The word being pushed on the last beat already contains this beat's data.
  assign shift_cat = {data_s, shift_q};
  assign shift_nxt = shift_cat[PACKET_W+NUM_LANES-1:NUM_LANES];

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == PTR_W'(DEPTH));
  assign rd_valid = (level != '0);
  assign pop      = rd_valid & rd_if.rd_ready_i;
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;

  assign rd_if.rd_valid_o = rd_valid;
  assign rd_if.rd_data_o  = rd_valid ? mem[rd_ptr_q[ADDR_W-1:0]] : '0;
  assign level_o          = level;
  assign overflow_o       = overflow_q;
  assign framing_err_o    = framing_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned
    // and no latch is inferred; combinational logic uses blocking '=' only.
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], clkPin_i};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], dataPin_i};
    clk_prev_d  = clk_s;
    shift_d     = shift_q;
    beat_d      = beat_q;
    idle_d      = idle_q;
    push        = 1'b0;
    framing_set = 1'b0;

    if (!enable_i) begin
      beat_d = '0;
      idle_d = '0;
    end else if (edge_det) begin
      shift_d = shift_nxt;
      idle_d  = '0;
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
        push   = 1'b1;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end else if (beat_q != '0 && IDLE_TIMEOUT != 0) begin
      // Mid-packet with no edge: abort once the idle count reaches the limit.
      if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
        beat_d      = '0;
        idle_d      = '0;
        framing_set = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = '0;
    end

    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    // A new error in the same cycle as a clear keeps the flag set.
    overflow_d = drop | (overflow_q & ~clear_err_i);
    framing_d  = framing_set | (framing_q & ~clear_err_i);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      shift_q     <= '0;
      beat_q      <= '0;
      idle_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      framing_q   <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      shift_q     <= shift_d;
      beat_q      <= beat_d;
      idle_q      <= idle_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      framing_q   <= framing_d;
    end
  end

  // NOTE: the storage array has no reset; empty pointers mask its contents and rd_data_o is
  // forced to zero while nothing is valid.
  always_ff @(posedge clk_800MHz) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= shift_nxt;
  end

endmodule
